uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: RATIO_WIDTH, default 16, width of the bit-period ratio input.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high: i_uart_arb_clk  in  1  sole clock, all logic on rising edge.
REQ-003 The block SHALL have i_uart_arb_rst  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have i_uart_arb_ratio  in  RATIO_WIDTH  clocks per serial bit; 0 and 1 both mean 1 clock per bit.
REQ-005 The block SHALL have i_uart_arb_par_en  in  1  parity bit enable.
REQ-006 The block SHALL have i_uart_arb_par_odd  in  1  1 = odd parity, 0 = even parity.
REQ-007 The block SHALL have i_uart_arb_req0_valid / i_uart_arb_req1_valid  in  1 each  requester has a byte.
REQ-008 The block SHALL have i_uart_arb_req0_data / i_uart_arb_req1_data  in  8 each  byte to send.
REQ-009 The block SHALL have o_uart_arb_req0_ready / o_uart_arb_req1_ready  out  1 each  byte accepted this cycle.
REQ-010 The block SHALL have o_uart_arb_tx  out  1  serial line, idle high.
REQ-011 The block SHALL have o_uart_arb_busy  out  1  high from START through STOP.
REQ-012 The block SHALL have o_uart_arb_grant  out  2  one-hot owner of the current frame, 00 when idle.
REQ-013 The block SHALL have o_uart_arb_frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-015 In IDLE, ready SHALL be driven combinationally high for exactly one requester: the only valid one, or, if both are valid, the one not granted last (round-robin); a transfer occurs when valid && ready.
REQ-016 The round-robin pointer SHALL update only on a transfer, giving the just-served requester lowest priority.
REQ-017 On transfer, the block SHALL latch the data byte, the effective ratio (max(ratio,1)), par_en and par_odd; later changes to these inputs SHALL NOT affect the frame in flight.
REQ-018 On transfer, the block SHALL go to START next cycle and set grant to the winner one-hot, held until STOP ends.
REQ-019 Each of START, each DATA bit, PARITY and STOP SHALL last exactly R clocks (R = latched effective ratio), timed by an internal RATIO_WIDTH-bit counter that reloads at each bit boundary.
REQ-020 tx SHALL be 0 in START, data LSB-first in DATA (8 bits, 3-bit index), parity bit in PARITY, and 1 in STOP and IDLE.
REQ-021 The parity bit SHALL be the XOR of the 8 data bits for even parity, inverted for odd parity; PARITY SHALL be skipped (DATA -> STOP) when par_en = 0.
REQ-022 On the last STOP clock, frame_done SHALL pulse for one cycle coincident with the transition to IDLE; grant and busy SHALL clear in that same transition.
REQ-023 After STOP, IDLE SHALL last at least one cycle, so the earliest next transfer is the first IDLE cycle and back-to-back frames are 10R+1 clocks (11R+1 with parity) apart.
REQ-024 ready SHALL be 0 in every non-IDLE state; valid asserted mid-frame SHALL be held off with no loss.
REQ-025 Requester valid deasserted before acceptance SHALL NOT be granted, and no frame SHALL start.

Reset
REQ-026 While rst = 1 at a clock edge, the block SHALL set the state to IDLE, tx=1, busy=0, grant=00, frame_done=0, both readies=0 on the following cycle, counter and bit index to 0, and the pointer to favour req0.
REQ-027 A reset asserted mid-frame SHALL abort the frame (tx high the next cycle, no frame_done) and SHALL NOT return ready to that requester for the lost byte.

Verification
REQ-028 Ratio 4, no parity, req0 sends 0xA5 -> ready0 pulse, tx = 0,1,0,1,0,0,1,0,1,1 with each bit 4 clocks, frame_done at clock 40 after acceptance.
REQ-029 Both valid continuously, ratio 2 -> grants alternate 01,10,01,10 starting with req0 after reset; each frame is 20 clocks followed by 1 idle cycle.
REQ-030 Ratio 0 and ratio 1, req1 sends 0x00 with even parity -> 1 clock per bit, parity bit 0, 11-clock frame; odd parity gives a parity bit of 1.
REQ-031 Change the ratio from 3 to 8 and toggle par_en during a frame -> the frame in flight keeps 3 clocks per bit and its original parity; the next frame uses 8.
REQ-032 Assert rst during DATA bit 3 -> tx=1, busy=0, grant=00 next cycle, no frame_done; after release req0 wins when both are valid.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester UART transmitter. A round-robin arbiter
// picks one byte at a time in IDLE and the serializer sends it as
// START, 8 data bits (LSB first), optional PARITY, then STOP. Each bit lasts
// R clocks, where R = max(ratio, 1) is captured when the byte is accepted.
//
// Ports:
//   i_uart_arb_clk / i_uart_arb_rst     clock, synchronous active-high reset
//   i_uart_arb_ratio                    clocks per serial bit (0 treated as 1)
//   i_uart_arb_par_en / _par_odd        parity enable / odd(1) or even(0)
//   i_uart_arb_reqN_valid / _data       requester N offers a byte
//   o_uart_arb_reqN_ready               byte from requester N accepted this cycle
//   o_uart_arb_tx                       serial line, idle high
//   o_uart_arb_busy                     high from START through STOP
//   o_uart_arb_grant                    one-hot owner of current frame, 00 idle
//   o_uart_arb_frame_done               one-cycle pulse on the last STOP clock
//
// state  | meaning
// IDLE   | line high, arbiter offers ready to one valid requester
// START  | start bit (tx = 0) for R clocks
// DATA   | 8 data bits LSB first, R clocks each
// PARITY | parity bit for R clocks (skipped when parity disabled)
// STOP   | stop bit (tx = 1) for R clocks, frame_done on the last clock

module uart_tx_arbiter #(
    parameter int RATIO_WIDTH = 16
) (
    input  logic                   i_uart_arb_clk,
    input  logic                   i_uart_arb_rst,
    input  logic [RATIO_WIDTH-1:0] i_uart_arb_ratio,
    input  logic                   i_uart_arb_par_en,
    input  logic                   i_uart_arb_par_odd,
    input  logic                   i_uart_arb_req0_valid,
    input  logic [7:0]             i_uart_arb_req0_data,
    input  logic                   i_uart_arb_req1_valid,
    input  logic [7:0]             i_uart_arb_req1_data,
    output logic                   o_uart_arb_req0_ready,
    output logic                   o_uart_arb_req1_ready,
    output logic                   o_uart_arb_tx,
    output logic                   o_uart_arb_busy,
    output logic [1:0]             o_uart_arb_grant,
    output logic                   o_uart_arb_frame_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [RATIO_WIDTH-1:0] ONE = RATIO_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [RATIO_WIDTH-1:0] r_cnt;
    logic [RATIO_WIDTH-1:0] r_ratio;
    logic [RATIO_WIDTH-1:0] w_eff_ratio;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_data;
    logic                   r_par_en;
    logic                   r_par_odd;
    logic                   r_rr_ptr;     // 0: req0 wins a tie, 1: req1 wins
    logic [1:0]             r_grant;
    logic                   w_idle;
    logic                   w_bit_end;
    logic                   w_ready0;
    logic                   w_ready1;
    logic                   w_xfer;

    assign w_idle      = (r_state == S_IDLE);
    assign w_bit_end   = (r_cnt == '0);
    assign w_eff_ratio = (i_uart_arb_ratio == '0) ? ONE : i_uart_arb_ratio;

    // Ready is withheld while reset is asserted so no byte is taken that the
    // reset would immediately discard.
    assign w_ready0 = w_idle && !i_uart_arb_rst && i_uart_arb_req0_valid &&
                      (!i_uart_arb_req1_valid || !r_rr_ptr);
    assign w_ready1 = w_idle && !i_uart_arb_rst && i_uart_arb_req1_valid &&
                      (!i_uart_arb_req0_valid || r_rr_ptr);
    assign w_xfer   = w_ready0 || w_ready1;

    // State register
    always_ff @(posedge i_uart_arb_clk) begin
        if (i_uart_arb_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_xfer) w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA:   if (w_bit_end && (r_bit_idx == 3'd7))
                          w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
            S_STOP:   if (w_bit_end) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Frame datapath: captured byte/config, bit timer, bit index, arbitration
    always_ff @(posedge i_uart_arb_clk) begin
        if (i_uart_arb_rst) begin
            r_cnt     <= '0;
            r_ratio   <= ONE;
            r_bit_idx <= 3'd0;
            r_data    <= 8'd0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_grant   <= 2'b00;
        end else if (w_xfer) begin
            r_data    <= w_ready1 ? i_uart_arb_req1_data : i_uart_arb_req0_data;
            r_ratio   <= w_eff_ratio;
            r_par_en  <= i_uart_arb_par_en;
            r_par_odd <= i_uart_arb_par_odd;
            r_cnt     <= w_eff_ratio - ONE;
            r_bit_idx <= 3'd0;
            r_grant   <= w_ready1 ? 2'b10 : 2'b01;
            // The requester just served drops to lowest priority.
            r_rr_ptr  <= w_ready0;
        end else if (!w_idle) begin
            if (w_bit_end) begin
                if (r_state == S_STOP) begin
                    r_cnt   <= '0;
                    r_grant <= 2'b00;
                end else begin
                    r_cnt <= r_ratio - ONE;
                end
                if (r_state == S_DATA) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_cnt <= r_cnt - ONE;
            end
        end
    end

    // Outputs
    always_comb begin
        o_uart_arb_tx = 1'b1;
        unique case (r_state)
            S_START:  o_uart_arb_tx = 1'b0;
            S_DATA:   o_uart_arb_tx = r_data[r_bit_idx];
            S_PARITY: o_uart_arb_tx = (^r_data) ^ r_par_odd;
            default:  o_uart_arb_tx = 1'b1;
        endcase
        o_uart_arb_busy       = !w_idle;
        o_uart_arb_grant      = r_grant;
        o_uart_arb_frame_done = (r_state == S_STOP) && w_bit_end;
        o_uart_arb_req0_ready = w_ready0;
        o_uart_arb_req1_ready = w_ready1;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: table of frames plus random frames checked
// against a bit-list model of the UART frame, and hand-written sequences for
// round-robin spacing and mid-frame reset.

module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ratio;
    logic        pe, po;
    logic        v0, v1;
    logic [7:0]  d0, d1;
    logic        r0, r1, tx, busy, fd;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_tx_arbiter #(.RATIO_WIDTH(16)) dut (
        .i_uart_arb_clk        (clk),
        .i_uart_arb_rst        (rst),
        .i_uart_arb_ratio      (ratio),
        .i_uart_arb_par_en     (pe),
        .i_uart_arb_par_odd    (po),
        .i_uart_arb_req0_valid (v0),
        .i_uart_arb_req0_data  (d0),
        .i_uart_arb_req1_valid (v1),
        .i_uart_arb_req1_data  (d1),
        .o_uart_arb_req0_ready (r0),
        .o_uart_arb_req1_ready (r1),
        .o_uart_arb_tx         (tx),
        .o_uart_arb_busy       (busy),
        .o_uart_arb_grant      (grant),
        .o_uart_arb_frame_done (fd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         who;
        logic [7:0] data;
        int         ratio;
        bit         pe;
        bit         po;
        int         pert;     // 0 none, 1 change config mid-frame, 2 other valid glitch
        int         exp_len;  // clocks from acceptance to frame_done
        int         exp_par;  // expected parity bit, -1 if none
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one byte from requester 'who' and check the whole frame against a
    // list of serial bits built straight from the frame format.
    task automatic send_frame(input int who, input logic [7:0] d, input int rat,
                              input bit p_en, input bit p_odd, input int pert,
                              input int exp_len, input int exp_par);
        int r, nb, n, done_at, k;
        int bits[11];
        logic [1:0] g;
        logic       rdy;
        r  = (rat < 1) ? 1 : rat;
        nb = 0;
        bits[nb++] = 0;
        for (int i = 0; i < 8; i++) bits[nb++] = int'(d[i]);
        if (p_en) bits[nb++] = int'((^d) ^ p_odd);
        bits[nb++] = 1;
        n = nb * r;
        g = (who == 1) ? 2'b10 : 2'b01;

        ratio = 16'(rat);
        pe    = p_en;
        po    = p_odd;
        if (who == 1) begin v1 = 1'b1; d1 = d; end
        else          begin v0 = 1'b1; d0 = d; end
        #1;
        k = 0;
        rdy = (who == 1) ? r1 : r0;
        while (!rdy && k < 50) begin
            tick();
            rdy = (who == 1) ? r1 : r0;
            k++;
        end
        chk("accept_ready", rdy, 1);
        chk("accept_other_ready", (who == 1) ? r0 : r1, 0);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        d0 = ~d; d1 = ~d;
        done_at = 0;
        for (int c = 1; c <= n; c++) begin
            if (pert == 1 && c == 2) begin
                ratio = 16'd8;
                pe    = ~pe;
                po    = ~po;
            end
            if (pert == 2 && c == 2) begin
                if (who == 1) v0 = 1'b1; else v1 = 1'b1;
            end
            if (pert == 2 && c == 4) begin
                v0 = 1'b0; v1 = 1'b0;
            end
            #1;
            chk("tx_bit", tx, bits[(c-1)/r]);
            chk("busy_frame", busy, 1);
            chk("grant_frame", grant, g);
            chk("ready_held_off", {r0, r1}, 2'b00);
            chk("frame_done_pos", fd, (c == n) ? 1 : 0);
            if (fd && done_at == 0) done_at = c;
            if (p_en && exp_par >= 0 && c == 9*r + 1) chk("parity_bit", tx, exp_par[0]);
            tick();
        end
        chk("frame_len", done_at, exp_len);
        #1;
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);
        chk("idle_grant", grant, 2'b00);
        chk("idle_frame_done", fd, 0);
        tick();
        chk("no_spurious_start", busy, 0);
    endtask

    initial begin
        int prev, k, who, rr;
        bit exp0;
        logic [7:0] rd;
        vecs[0] = '{0, 8'hA5, 4, 1'b0, 1'b0, 0, 40, -1};
        vecs[1] = '{1, 8'h00, 0, 1'b1, 1'b0, 0, 11, 0};
        vecs[2] = '{1, 8'h00, 1, 1'b1, 1'b0, 0, 11, 0};
        vecs[3] = '{1, 8'h00, 1, 1'b1, 1'b1, 0, 11, 1};
        vecs[4] = '{0, 8'h3C, 3, 1'b1, 1'b0, 1, 33, 0};
        vecs[5] = '{0, 8'h3C, 8, 1'b0, 1'b1, 0, 80, -1};
        vecs[6] = '{1, 8'h81, 2, 1'b1, 1'b1, 2, 22, 1};
        vecs[7] = '{0, 8'hFF, 5, 1'b1, 1'b0, 0, 55, 0};

        rst = 1'b1; ratio = 16'd1; pe = 1'b0; po = 1'b0;
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
        tick(); tick();
        chk("rst_ready", {r0, r1}, 2'b00);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_frame_done", fd, 0);
        v0 = 1'b0; v1 = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_idle", busy, 0);

        for (int i = 0; i < 8; i++)
            send_frame(vecs[i].who, vecs[i].data, vecs[i].ratio, vecs[i].pe,
                       vecs[i].po, vecs[i].pert, vecs[i].exp_len, vecs[i].exp_par);

        for (int i = 0; i < 10; i++) begin
            who = int'($urandom_range(0, 1));
            rd  = 8'($urandom_range(0, 255));
            rr  = int'($urandom_range(0, 4));
            pe  = 1'($urandom_range(0, 1));
            po  = 1'($urandom_range(0, 1));
            send_frame(who, rd, rr, pe, po, 0,
                       (pe ? 11 : 10) * ((rr < 1) ? 1 : rr), -1);
        end

        // Reset during DATA bit 3 (ratio 2: bit 3 spans clocks 9..10).
        ratio = 16'd2; pe = 1'b0; po = 1'b0;
        v0 = 1'b1; d0 = 8'h5A;
        #1;
        k = 0;
        while (!r0 && k < 50) begin tick(); k++; end
        chk("abort_accept", r0, 1);
        tick();
        v0 = 1'b0;
        for (int c = 1; c < 9; c++) tick();
        chk("abort_bit3_tx", tx, 1);   // 0x5A bit 3 = 1
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d1 = 8'hC3;
        tick();
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_grant", grant, 2'b00);
        chk("abort_frame_done", fd, 0);
        chk("abort_ready", {r0, r1}, 2'b00);
        rst = 1'b0;
        #1;
        chk("abort_rr_req0", {r0, r1}, 2'b10);

        // Both requesters valid continuously at ratio 2: alternating grants,
        // 20-clock frames, next acceptance 21 clocks after the previous.
        prev = 0;
        for (int f = 0; f < 4; f++) begin
            exp0 = (f % 2 == 0);
            k = 0;
            while (!(r0 || r1) && k < 60) begin tick(); k++; end
            chk("rr_ready", {r0, r1}, exp0 ? 2'b10 : 2'b01);
            if (f > 0) chk("rr_gap", cyc - prev, 21);
            prev = cyc;
            tick();
            chk("rr_grant", grant, exp0 ? 2'b01 : 2'b10);
            for (int c = 2; c <= 20; c++) begin
                tick();
                chk("rr_frame_done", fd, (c == 20) ? 1 : 0);
            end
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
